// File: rtl/legv8_pkg.sv
`default_nettype none
// ============================================================================
// Package  : legv8_pkg
// Purpose  : LEGv8 op codes, opcode fields and immediate widths shared with decode
// Revision : 1.0
// ============================================================================
package legv8_pkg;

    typedef enum logic [3:0] {
        ADDI = 4'd0,
        ADDS = 4'd1,
        SUBS = 4'd2,
        B    = 4'd3,
        BLT  = 4'd4,
        BL   = 4'd5,
        BR   = 4'd6,
        CBZ  = 4'd7,
        LDUR = 4'd8,
        STUR = 4'd9
    } op_e;

    localparam logic [9:0]  c_opc_addi  = 10'b1001000100;
    localparam logic [10:0] c_opc_adds  = 11'b10101011000;
    localparam logic [10:0] c_opc_subs  = 11'b11101011000;
    localparam logic [5:0]  c_opc_b     = 6'b000101;
    localparam logic [5:0]  c_opc_bl    = 6'b100101;
    localparam logic [7:0]  c_opc_bcond = 8'b01010100;
    localparam logic [7:0]  c_opc_cbz   = 8'b10110100;
    localparam logic [10:0] c_opc_br    = 11'b11010110000;
    localparam logic [10:0] c_opc_ldur  = 11'b11111000010;
    localparam logic [10:0] c_opc_stur  = 11'b11111000000;

    localparam logic [4:0]  COND_LT     = 5'b01011;

    localparam int c_imm9_w  = 9;
    localparam int c_imm12_w = 12;
    localparam int c_imm19_w = 19;
    localparam int c_imm26_w = 26;

    typedef struct packed {
        logic        ok;
        logic [31:0] word;
    } enc_t;

    // True when the 26-bit request immediate is a sign extension of a w-bit value.
    function automatic logic fits_signed(input logic [25:0] imm, input int w);
        logic r;
        r = 1'b1;
        for (int i = w; i < c_imm26_w; i++) begin
            if (imm[i] != imm[w-1]) r = 1'b0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO, power-of-2 depth, optional first-word-fall-through
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter bit          FWFT  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (c_aw+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_aw'(1);
            if (w_pop)  r_rptr <= r_rptr + c_aw'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

    generate
        if (FWFT) begin : g_fwft
            assign dout = r_mem[r_rptr];
        end else begin : g_std
            logic [WIDTH-1:0] r_dout;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)   r_dout <= '0;
                else if (w_pop) r_dout <= r_mem[r_rptr];
            end
            assign dout = r_dout;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/legv8_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : legv8_instr_encoder
// Purpose  : Packs symbolic LEGv8 requests into words and streams them to imem
// Revision : 1.0
// ============================================================================
module legv8_instr_encoder
    import legv8_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter int unsigned MAX_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        finish,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rn,
    input  logic [4:0]  req_rm,
    input  logic [25:0] req_imm,
    output logic        imem_we,
    input  logic        imem_ready,
    output logic [63:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        err,
    output logic        full,
    output logic        done,
    output logic [10:0] word_count
);
    localparam int unsigned c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [63:0]        r_addr;
    logic [10:0]        r_count;
    logic               r_err;
    logic [c_cnt_w-1:0] w_occ;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [31:0]        w_fifo_dout;
    logic [31:0]        w_total;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    enc_t               w_enc;

    function automatic enc_t encode(input logic [3:0] op, input logic [4:0] rd,
                                    input logic [4:0] rn, input logic [4:0] rm,
                                    input logic [25:0] imm);
        enc_t e;
        e.ok   = 1'b1;
        e.word = '0;
        case (op)
            ADDI: begin
                e.ok   = ((imm >> c_imm12_w) == '0);
                e.word = {c_opc_addi, imm[c_imm12_w-1:0], rn, rd};
            end
            ADDS: e.word = {c_opc_adds, rm, 6'b0, rn, rd};
            SUBS: e.word = {c_opc_subs, rm, 6'b0, rn, rd};
            B:    e.word = {c_opc_b, imm};
            BL:   e.word = {c_opc_bl, imm};
            BLT: begin
                e.ok   = fits_signed(imm, c_imm19_w);
                e.word = {c_opc_bcond, imm[c_imm19_w-1:0], COND_LT};
            end
            CBZ: begin
                e.ok   = fits_signed(imm, c_imm19_w);
                e.word = {c_opc_cbz, imm[c_imm19_w-1:0], rd};
            end
            BR:   e.word = {c_opc_br, 16'b0, rd};
            LDUR: begin
                e.ok   = fits_signed(imm, c_imm9_w);
                e.word = {c_opc_ldur, imm[c_imm9_w-1:0], 2'b00, rn, rd};
            end
            STUR: begin
                e.ok   = fits_signed(imm, c_imm9_w);
                e.word = {c_opc_stur, imm[c_imm9_w-1:0], 2'b00, rn, rd};
            end
            default: e.ok = 1'b0;
        endcase
        return e;
    endfunction

    assign w_enc    = encode(req_op, req_rd, req_rn, req_rm, req_imm);
    // Buffered words count against the limit so the FIFO never overshoots MAX_WORDS.
    assign w_total  = 32'(r_count) + 32'(w_occ);
    assign req_ready = (r_state == S_LOAD) && !w_fifo_full && (w_total < MAX_WORDS);
    assign w_accept = req_valid && req_ready;
    assign w_push   = w_accept && w_enc.ok && !start;
    assign imem_we  = !w_fifo_empty;
    assign w_pop    = imem_we && imem_ready && !start;

    assign imem_addr  = r_addr;
    assign imem_wdata = w_fifo_dout;
    assign word_count = r_count;
    assign err        = r_err;
    assign full       = (32'(r_count) == MAX_WORDS);
    assign done       = (r_state == S_DONE);

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH),
        .FWFT  (1'b1)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start),
        .push    (w_push),
        .din     (w_enc.word),
        .pop     (w_pop),
        .dout    (w_fifo_dout),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_occ)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_accept && !w_enc.ok && !start;
            if (start) begin
                r_addr  <= BASE_ADDR;
                r_count <= '0;
            end else if (w_pop) begin
                r_addr  <= r_addr + 64'd4;
                r_count <= r_count + 11'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD:  if (finish) w_state_nxt = S_FLUSH;
                S_FLUSH: if (w_fifo_empty) w_state_nxt = S_DONE;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_legv8_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_legv8_instr_encoder
// Purpose  : Scoreboard bench for legv8_instr_encoder
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_legv8_instr_encoder;
    import legv8_pkg::*;

    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, finish = 1'b0;
    logic        req_valid = 1'b0, imem_ready = 1'b0;
    logic [3:0]  req_op = '0;
    logic [4:0]  req_rd = '0, req_rn = '0, req_rm = '0;
    logic [25:0] req_imm = '0;
    logic        req_ready, imem_we, err, full, done;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [10:0] word_count;

    logic        l_start = 1'b0, l_req_valid = 1'b0;
    logic        l_req_ready, l_we, l_err, l_full, l_done;
    logic [63:0] l_addr;
    logic [31:0] l_wdata;
    logic [10:0] l_wc;

    int          n_checks = 0, n_fail = 0, n_ok = 0, l_acc = 0, l_writes = 0;
    logic [31:0] cur_exp = '0;
    logic        cur_ok = 1'b1;
    logic        err_pending = 1'b0;
    logic [63:0] exp_waddr = '0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    legv8_instr_encoder dut (
        .clk(clk), .reset_n(reset_n), .start(start), .finish(finish),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm), .req_imm(req_imm),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .err(err), .full(full), .done(done),
        .word_count(word_count)
    );

    legv8_instr_encoder #(.MAX_WORDS(3)) dut_lim (
        .clk(clk), .reset_n(reset_n), .start(l_start), .finish(1'b0),
        .req_valid(l_req_valid), .req_ready(l_req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm), .req_imm(req_imm),
        .imem_we(l_we), .imem_ready(imem_ready), .imem_addr(l_addr),
        .imem_wdata(l_wdata), .err(l_err), .full(l_full), .done(l_done),
        .word_count(l_wc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoding built from the instruction formats as hex bases.
    function automatic logic [32:0] model(input logic [3:0] op, input logic [4:0] rd,
                                          input logic [4:0] rn, input logic [4:0] rm,
                                          input logic [25:0] imm);
        int s;
        s = int'({{6{imm[25]}}, imm});
        case (op)
            4'd0: return {s >= 0 && s <= 4095, 32'h91000000 | (32'(imm[11:0]) << 10) | (32'(rn) << 5) | 32'(rd)};
            4'd1: return {1'b1, 32'hAB000000 | (32'(rm) << 16) | (32'(rn) << 5) | 32'(rd)};
            4'd2: return {1'b1, 32'hEB000000 | (32'(rm) << 16) | (32'(rn) << 5) | 32'(rd)};
            4'd3: return {1'b1, 32'h14000000 | 32'(imm)};
            4'd4: return {s >= -262144 && s <= 262143, 32'h54000000 | (32'(imm[18:0]) << 5) | 32'h0B};
            4'd5: return {1'b1, 32'h94000000 | 32'(imm)};
            4'd6: return {1'b1, 32'hD6000000 | 32'(rd)};
            4'd7: return {s >= -262144 && s <= 262143, 32'hB4000000 | (32'(imm[18:0]) << 5) | 32'(rd)};
            4'd8: return {s >= -256 && s <= 255, 32'hF8400000 | (32'(imm[8:0]) << 12) | (32'(rn) << 5) | 32'(rd)};
            4'd9: return {s >= -256 && s <= 255, 32'hF8000000 | (32'(imm[8:0]) << 12) | (32'(rn) << 5) | 32'(rd)};
            default: return 33'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            sb_q.delete();
            exp_waddr   = '0;
            err_pending = 1'b0;
        end else begin
            check("err", {63'b0, err}, {63'b0, err_pending});
            if (start) begin
                sb_q.delete();
                exp_waddr   = '0;
                err_pending = 1'b0;
            end else begin
                if (imem_we && imem_ready) begin
                    if (sb_q.size() > 0) check("wdata", {32'h1, imem_wdata}, {32'h1, sb_q.pop_front()});
                    else                 check("unexpected_write", {32'h1, imem_wdata}, 64'h0);
                    check("waddr", imem_addr, exp_waddr);
                    exp_waddr += 64'd4;
                end
                err_pending = req_valid && req_ready && !cur_ok;
                if (req_valid && req_ready && cur_ok) sb_q.push_back(cur_exp);
            end
            if (l_req_valid && l_req_ready && !l_start) l_acc++;
            if (l_we && imem_ready && !l_start) l_writes++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_ok  = 0;
    endtask

    task automatic set_req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                           input logic [4:0] rm, input logic [25:0] imm,
                           input logic [31:0] exp, input logic ok);
        req_op = op; req_rd = rd; req_rn = rn; req_rm = rm; req_imm = imm;
        cur_exp = exp;
        cur_ok  = ok;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [25:0] imm,
                        input logic [31:0] exp, input logic ok);
        bit got;
        got = 1'b0;
        set_req(op, rd, rn, rm, imm, exp, ok);
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) check("send_timeout", {63'b0, req_ready}, 64'd1);
        if (ok) n_ok++;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic send_m(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                          input logic [4:0] rm, input logic [25:0] imm);
        logic [32:0] m;
        m = model(op, rd, rn, rm, imm);
        send(op, rd, rn, rm, imm, m[31:0], m[32]);
    endtask

    initial begin
        logic [32:0] m;
        logic [63:0] snap_addr;
        logic [31:0] snap_data;
        int          k;
        bit          took;

        imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {63'b0, req_ready}, 64'd0);
        check("rst_we",    {63'b0, imem_we}, 64'd0);
        check("rst_done",  {63'b0, done}, 64'd0);
        check("rst_full",  {63'b0, full}, 64'd0);
        check("rst_wc",    {53'b0, word_count}, 64'd0);
        check("rst_addr",  imem_addr, 64'h0);
        reset_n = 1'b1;
        tick();

        // Directed encodes with the documented words
        pulse_start();
        send(ADDI, 5'd3, 5'd1, 5'd0, 26'd5, 32'h91001423, 1'b1);
        @(negedge clk);
        check("lat_we",   {63'b0, imem_we}, 64'd1);
        check("lat_addr", imem_addr, 64'h0);
        tick();
        send(SUBS, 5'd2, 5'd0, 5'd1, 26'd0, 32'hEB010002, 1'b1);
        send(B,    5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 32'h17FFFFFF, 1'b1);
        send(BLT,  5'd0, 5'd0, 5'd0, 26'd2, 32'h5400004B, 1'b1);
        send(LDUR, 5'd4, 5'd5, 5'd0, 26'h3FFFFF8, 32'hF85F80A4, 1'b1);
        send_m(BL,   5'd0,  5'd0, 5'd0, 26'h0000123);
        send_m(BR,   5'd30, 5'd0, 5'd0, 26'd0);
        send_m(CBZ,  5'd7,  5'd0, 5'd0, 26'h3FFFFFD);
        send_m(STUR, 5'd1,  5'd2, 5'd0, 26'd255);
        send_m(ADDI, 5'd9,  5'd8, 5'd0, 26'd4095);
        send_m(LDUR, 5'd6,  5'd7, 5'd0, 26'h3FFFF00);
        send_m(BLT,  5'd0,  5'd0, 5'd0, 26'h3FC0000);
        send_m(ADDS, 5'd31, 5'd30, 5'd29, 26'd0);
        // Out-of-range boundaries
        send_m(LDUR, 5'd1, 5'd1, 5'd0, 26'd256);
        send_m(STUR, 5'd1, 5'd1, 5'd0, 26'h3FFFEFF);
        send_m(CBZ,  5'd1, 5'd0, 5'd0, 26'h0040000);
        send_m(ADDI, 5'd1, 5'd1, 5'd0, 26'h3FFFFFF);
        repeat (3) tick();
        check("dir_wc", {53'b0, word_count}, 64'(n_ok));

        // Rejects leave the address untouched
        pulse_start();
        send(ADDI, 5'd1, 5'd1, 5'd0, 26'd4096, 32'h0, 1'b0);
        send(4'd15, 5'd1, 5'd1, 5'd1, 26'd0, 32'h0, 1'b0);
        repeat (2) tick();
        check("rej_wc0", {53'b0, word_count}, 64'd0);
        check("rej_we",  {63'b0, imem_we}, 64'd0);
        send_m(ADDI, 5'd2, 5'd2, 5'd0, 26'd7);
        repeat (2) tick();
        check("rej_wc1", {53'b0, word_count}, 64'd1);

        // Backpressure with continuous requests
        imem_ready = 1'b0;
        pulse_start();
        k = 0;
        snap_addr = '0;
        snap_data = '0;
        for (int i = 0; i < 10; i++) begin
            m = model(ADDS, 5'(k + 1), 5'(k + 2), 5'(k + 3), 26'd0);
            set_req(ADDS, 5'(k + 1), 5'(k + 2), 5'(k + 3), 26'd0, m[31:0], m[32]);
            req_valid = 1'b1;
            @(negedge clk);
            took = req_ready;
            if (i == 2) begin
                snap_addr = imem_addr;
                snap_data = imem_wdata;
            end
            tick();
            if (took) k++;
        end
        req_valid = 1'b0;
        check("bp_accepts", 64'(k), 64'd4);
        check("bp_ready",   {63'b0, req_ready}, 64'd0);
        check("bp_addr",    imem_addr, snap_addr);
        check("bp_data",    {32'b0, imem_wdata}, {32'b0, snap_data});
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_drain_we", {63'b0, imem_we}, 64'd1);
        end
        @(negedge clk);
        check("bp_drained", {63'b0, imem_we}, 64'd0);
        tick();

        // finish drains the buffer under toggling backpressure
        imem_ready = 1'b0;
        pulse_start();
        send_m(ADDS, 5'd1, 5'd2, 5'd3, 26'd0);
        send_m(SUBS, 5'd4, 5'd5, 5'd6, 26'd0);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        m = model(ADDI, 5'd1, 5'd1, 5'd0, 26'd1);
        set_req(ADDI, 5'd1, 5'd1, 5'd0, 26'd1, m[31:0], m[32]);
        req_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("fin_ready", {63'b0, req_ready}, 64'd0);
            if (done) break;
            tick();
            imem_ready = ~imem_ready;
        end
        check("fin_done", {63'b0, done}, 64'd1);
        check("fin_wc",   {53'b0, word_count}, 64'd2);
        tick();
        req_valid = 1'b0;
        pulse_start();
        check("restart_done", {63'b0, done}, 64'd0);
        check("restart_addr", imem_addr, 64'h0);
        check("restart_wc",   {53'b0, word_count}, 64'd0);

        // Image size limit on the MAX_WORDS=3 instance
        imem_ready = 1'b1;
        l_acc = 0;
        l_writes = 0;
        set_req(ADDI, 5'd1, 5'd1, 5'd0, 26'd1, 32'h0, 1'b1);
        l_start = 1'b1;
        tick();
        l_start = 1'b0;
        l_req_valid = 1'b1;
        repeat (10) tick();
        l_req_valid = 1'b0;
        tick();
        check("lim_acc",    64'(l_acc), 64'd3);
        check("lim_writes", 64'(l_writes), 64'd3);
        check("lim_wc",     {53'b0, l_wc}, 64'd3);
        check("lim_full",   {63'b0, l_full}, 64'd1);
        check("lim_ready",  {63'b0, l_req_ready}, 64'd0);

        // Asynchronous reset while a write is pending
        imem_ready = 1'b0;
        pulse_start();
        send_m(ADDI, 5'd3, 5'd3, 5'd0, 26'd3);
        send_m(ADDI, 5'd4, 5'd4, 5'd0, 26'd4);
        @(negedge clk);
        check("pre_rst_we", {63'b0, imem_we}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_we",    {63'b0, imem_we}, 64'd0);
        check("arst_ready", {63'b0, req_ready}, 64'd0);
        check("arst_err",   {63'b0, err}, 64'd0);
        check("arst_full",  {63'b0, full}, 64'd0);
        check("arst_done",  {63'b0, done}, 64'd0);
        check("arst_wc",    {53'b0, word_count}, 64'd0);
        check("arst_addr",  imem_addr, 64'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        pulse_start();
        @(negedge clk);
        check("post_rst_we", {63'b0, imem_we}, 64'd0);
        check("post_rst_wc", {53'b0, word_count}, 64'd0);
        tick();
        imem_ready = 1'b1;
        send_m(LDUR, 5'd2, 5'd3, 5'd0, 26'd16);
        repeat (4) tick();
        check("post_rst_wc1", {53'b0, word_count}, 64'd1);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
